// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the carry-lookahead adder.
//   CLA_WIDTH/CLA_GROUP : default operand width and lookahead group size
//   cla_num_groups      : number of lookahead groups, ceil(width/group)
//   cla_params_ok       : legality of a width/group pair, used at elaboration
//   cla_carry           : flattened sum-of-products lookahead carry
package cla_pkg;

   localparam int CLA_WIDTH     = 3;
   localparam int CLA_GROUP     = 4;
   localparam int CLA_MAX_WIDTH = 64;

   function automatic int cla_num_groups(input int width, input int group);
      return (group < 1) ? width : (width + group - 1) / group;
   endfunction

   function automatic bit cla_params_ok(input int width, input int group);
      return (width >= 1) && (width <= CLA_MAX_WIDTH) && (group >= 1);
   endfunction

   // Carry into position n given generate/propagate vectors and a carry-in:
   //   c[n] = ci&p[0]&..&p[n-1] | OR_j g[j]&p[j+1]&..&p[n-1]
   // Every term is an independent AND, so the result is a two-level
   // AND-OR network rather than a ripple chain. Used both within a group
   // (bit g/p) and across groups (group GG/GP).
   function automatic logic cla_carry(input logic [CLA_MAX_WIDTH-1:0] g,
                                      input logic [CLA_MAX_WIDTH-1:0] p,
                                      input logic ci,
                                      input int n);
      logic c;
      logic t;
      c = ci;
      for (int k = 0; k < n; k++) c = c & p[k];
      for (int j = 0; j < n; j++) begin
         t = g[j];
         for (int k = j + 1; k < n; k++) t = t & p[k];
         c = c | t;
      end
      return c;
   endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: one lookahead group of N bits.
//   i_a, i_b : N-bit operand slices
//   i_ci     : carry into the group's bit 0
//   o_sum    : N-bit sum slice
//   o_gg     : group generate (carry out assuming carry-in 0)
//   o_gp     : group propagate (AND of the bit xor-propagates)
module cla_group
   import cla_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_ci,
   output logic [N-1:0] o_sum,
   output logic         o_gg,
   output logic         o_gp
);

   logic [N-1:0] w_g;
   logic [N-1:0] w_p;
   logic [N-1:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   always_comb begin
      w_c = '0;
      for (int i = 0; i < N; i++)
         w_c[i] = cla_carry(CLA_MAX_WIDTH'(w_g), CLA_MAX_WIDTH'(w_p), i_ci, i);
   end

   assign o_sum = w_p ^ w_c;
   assign o_gg  = cla_carry(CLA_MAX_WIDTH'(w_g), CLA_MAX_WIDTH'(w_p), 1'b0, N);
   assign o_gp  = &w_p;

endmodule

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: unsigned two-level carry-lookahead adder.
//   i_clk      : clock, used only by the registered output
//   i_rst      : synchronous active-high reset of o_result_q
//   i_add1     : operand A, WIDTH bits
//   i_add2     : operand B, WIDTH bits
//   o_result   : combinational i_add1+i_add2, bit WIDTH is the carry-out
//   o_result_q : o_result registered on the rising edge of i_clk
module carry_lookahead_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int GROUP = CLA_GROUP
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_add1,
   input  logic [WIDTH-1:0] i_add2,
   output logic [WIDTH:0]   o_result,
   output logic [WIDTH:0]   o_result_q
);

   localparam int NG = cla_num_groups(WIDTH, GROUP);

   if (!cla_params_ok(WIDTH, GROUP)) begin : g_bad_params
      $error("carry_lookahead_adder: WIDTH must be 1..64 and GROUP >= 1");
   end

   logic [NG-1:0]    w_gg;
   logic [NG-1:0]    w_gp;
   logic [NG:0]      w_cg;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH:0]   r_result_q;

   // Second-level lookahead: every group carry comes straight from the
   // group GG/GP terms; the adder carry-in is constant 0.
   always_comb begin
      w_cg = '0;
      for (int k = 0; k <= NG; k++)
         w_cg[k] = cla_carry(CLA_MAX_WIDTH'(w_gg), CLA_MAX_WIDTH'(w_gp), 1'b0, k);
   end

   // The final group takes whatever bits remain, so it may be narrower.
   for (genvar k = 0; k < NG; k++) begin : g_grp
      localparam int LO = k * GROUP;
      localparam int N  = (WIDTH - LO < GROUP) ? WIDTH - LO : GROUP;
      cla_group #(.N(N)) u_grp (
         .i_a   (i_add1[LO +: N]),
         .i_b   (i_add2[LO +: N]),
         .i_ci  (w_cg[k]),
         .o_sum (w_sum[LO +: N]),
         .o_gg  (w_gg[k]),
         .o_gp  (w_gp[k])
      );
   end

   assign o_result = {w_cg[NG], w_sum};

   always_ff @(posedge i_clk)
      r_result_q <= i_rst ? '0 : o_result;

   assign o_result_q = r_result_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// tb_carry_lookahead_adder: self-checking bench for several adder widths.
module tb_carry_lookahead_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]  a3, b3;
   logic [3:0]  r3, q3;
   logic [7:0]  a8, b8;
   logic [8:0]  r8, q8;
   logic [15:0] a16, b16;
   logic [16:0] r16, q16;
   logic [0:0]  a1, b1;
   logic [1:0]  r1, q1;
   logic [12:0] a13, b13;
   logic [13:0] r13, q13;

   carry_lookahead_adder #(.WIDTH(3), .GROUP(4)) u_d3 (
      .i_clk(clk), .i_rst(rst), .i_add1(a3), .i_add2(b3), .o_result(r3), .o_result_q(q3));
   carry_lookahead_adder #(.WIDTH(8), .GROUP(4)) u_d8 (
      .i_clk(clk), .i_rst(rst), .i_add1(a8), .i_add2(b8), .o_result(r8), .o_result_q(q8));
   carry_lookahead_adder #(.WIDTH(16), .GROUP(4)) u_d16 (
      .i_clk(clk), .i_rst(rst), .i_add1(a16), .i_add2(b16), .o_result(r16), .o_result_q(q16));
   carry_lookahead_adder #(.WIDTH(1), .GROUP(4)) u_d1 (
      .i_clk(clk), .i_rst(rst), .i_add1(a1), .i_add2(b1), .o_result(r1), .o_result_q(q1));
   carry_lookahead_adder #(.WIDTH(13), .GROUP(3)) u_d13 (
      .i_clk(clk), .i_rst(rst), .i_add1(a13), .i_add2(b13), .o_result(r13), .o_result_q(q13));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: the plain arithmetic sum of the zero-extended operands.
   function automatic logic [64:0] ref_sum(input longint unsigned x, input longint unsigned y);
      return 65'(x) + 65'(y);
   endfunction

   initial begin
      a3 = '0; b3 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      a1 = '0; b1 = '0; a13 = '0; b13 = '0;
      @(posedge clk); #1;
      check("reset q3", 65'(q3), 65'd0);
      check("reset q8", 65'(q8), 65'd0);
      check("reset q16", 65'(q16), 65'd0);
      check("reset q1", 65'(q1), 65'd0);
      check("reset q13", 65'(q13), 65'd0);
      @(negedge clk);
      a3 = 3'd5; b3 = 3'd6;
      repeat (2) begin
         @(posedge clk); #1;
         check("rst hold q3", 65'(q3), 65'd0);
         check("rst hold r3", 65'(r3), 65'd11);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("release q3", 65'(q3), 65'd11);
      @(negedge clk); a3 = 3'd1; b3 = 3'd2;
      @(posedge clk); #1;
      check("stream q3", 65'(q3), 65'd3);
      @(negedge clk); rst = 1'b1; a3 = 3'd7; b3 = 3'd7;
      #1 check("r3 in rst", 65'(r3), 65'd14);
      @(posedge clk); #1;
      check("mid rst q3", 65'(q3), 65'd0);
      check("mid rst r3", 65'(r3), 65'd14);
      @(negedge clk); rst = 1'b0;
      for (int pass = 0; pass < 10; pass++)
         for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
               @(negedge clk); a3 = 3'(x); b3 = 3'(y);
               #1 check("exh r3", 65'(r3), ref_sum(longint'(x), longint'(y)));
               @(posedge clk); #1;
               check("exh q3", 65'(q3), ref_sum(longint'(x), longint'(y)));
            end
      @(negedge clk);
      a3 = 3'd7; b3 = 3'd7; #1 check("3b 7+7", 65'(r3), 65'd14);
      a3 = 3'd7; b3 = 3'd1; #1 check("3b 7+1", 65'(r3), 65'd8);
      a3 = 3'd0; b3 = 3'd0; #1 check("3b 0+0", 65'(r3), 65'd0);
      a8 = 8'hFF; b8 = 8'h01; #1 check("8b max+1", 65'(r8), 65'h100);
      a8 = 8'hFF; b8 = 8'hFF; #1 check("8b max+max", 65'(r8), 65'h1FE);
      a8 = 8'h0F; b8 = 8'h01; #1 check("8b grp cross", 65'(r8), 65'h010);
      a16 = 16'h7FFF; b16 = 16'h0001; #1 check("16b 7fff+1", 65'(r16), 65'h08000);
      a16 = 16'hFFFF; b16 = 16'hFFFF; #1 check("16b max+max", 65'(r16), 65'h1FFFE);
      a16 = 16'hFFFF; b16 = 16'h0001; #1 check("16b max+1", 65'(r16), 65'h10000);
      a13 = 13'h1FFF; b13 = 13'h0001; #1 check("13b max+1", 65'(r13), 65'h2000);
      for (int x = 0; x < 2; x++)
         for (int y = 0; y < 2; y++) begin
            a1 = 1'(x); b1 = 1'(y);
            #1 check("1b pair", 65'(r1), ref_sum(longint'(x), longint'(y)));
         end
      @(posedge clk); #1;
      check("1b q", 65'(q1), 65'd2);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a16 = 16'($urandom); b16 = 16'($urandom);
         a8 = 8'($urandom); b8 = 8'($urandom);
         a13 = 13'($urandom); b13 = 13'($urandom);
         #1;
         check("rnd r16", 65'(r16), ref_sum(longint'(a16), longint'(b16)));
         check("rnd r8", 65'(r8), ref_sum(longint'(a8), longint'(b8)));
         check("rnd r13", 65'(r13), ref_sum(longint'(a13), longint'(b13)));
         @(posedge clk); #1;
         check("rnd q16", 65'(q16), ref_sum(longint'(a16), longint'(b16)));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/carry_lookahead_adder.md
Name: carry_lookahead_adder

Overview:
Parameterised unsigned adder built on carry-lookahead logic. It sums two WIDTH-bit operands and produces a WIDTH+1-bit result, with the carry-out in the MSB. The primary result is combinational, with zero latency. A registered copy of the result is provided for downstream pipelined consumers. It is a datapath leaf block used wherever a fast ripple-free add is needed.

Parameters:
WIDTH, 3, operand width in bits; legal range 1..64
GROUP, 4, bits per lookahead group; the last group may be partial when WIDTH is not a multiple of GROUP

Ports:
i_clk  input  1  clock; only the registered output uses it
i_rst  input  1  synchronous, active-high reset
i_add1  input  WIDTH  operand A, unsigned
i_add2  input  WIDTH  operand B, unsigned
o_result  output  WIDTH+1  combinational sum i_add1+i_add2; bit WIDTH is the carry-out
o_result_q  output  WIDTH+1  o_result registered on the rising edge of i_clk

Behaviour:
- One clock (i_clk); reset i_rst is synchronous and active-high.
- Bit level: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Carry-in to bit 0 is constant 0; there is no carry-in port.
- Within a group: c[i+1] = g[i] | (p[i] & c[i]), fully expanded as flattened lookahead terms, not rippled.
- Group level: each group emits group generate GG and group propagate GP (GP = AND of p, using p as xor-propagate).
- Group carries: c_grp[k+1] = GG[k] | (GP[k] & c_grp[k]), computed by a second-level lookahead across groups.
- Sum: s[i] = p[i] ^ c[i]. o_result[WIDTH-1:0] = s and o_result[WIDTH] = carry out of the MSB.
- o_result must equal (i_add1 + i_add2) mod 2^(WIDTH+1) for every input pair; the add can never overflow.
- o_result is purely combinational: zero-cycle latency, valid within the same cycle the inputs change, and not affected by i_rst.
- o_result_q: on a rising edge of i_clk with i_rst=1 it loads 0. Otherwise it loads o_result, giving 1-cycle latency.
- Reset asserted mid-stream clears only o_result_q on the next edge; o_result keeps tracking the inputs.
- Boundaries:
  - 0+0 gives 0 with carry 0.
  - Maximum operands give 2^(WIDTH+1)-2.
  - An all-propagate chain (e.g. max+1) must carry through every group correctly, giving 2^WIDTH.
- WIDTH=1 degenerates to a single partial group; the result must still be correct.
- No X propagation on known inputs. No latches. No internal state other than o_result_q.

Decomposition:
- Shared package cla_pkg:
  - localparam function for the number of groups, ceil(WIDTH/GROUP)
  - default WIDTH/GROUP constants
  - a width-check helper for the elaboration-time assertion WIDTH>=1, GROUP>=1
- One sub-module, cla_group:
  - parameter N (group width)
  - inputs: N-bit a, b and carry-in
  - outputs: N-bit sum, group generate, group propagate
  - instantiated by generate loop; the final group is sized to the remainder.
- Top level holds the second-level carry lookahead and the output register.

Test Plan:
- WIDTH=3:
  - Exhaustive all 64 operand pairs, driven on negedge and checked on the next posedge; repeat 10 passes. -> o_result == i_add1+i_add2 every cycle, with zero errors reported.
  - 7+7 -> o_result=14 (4'b1110); 7+1 -> o_result=8 (carry-out only); 0+0 -> 0.
- Registered output:
  - Hold i_rst=1 for 2 edges with 5+6 applied -> o_result_q=0 while o_result=11.
  - Release reset -> o_result_q=11 one edge later.
  - Assert reset mid-stream -> o_result_q=0 on the next edge.
- WIDTH=8, GROUP=4: 255+1 -> 256; 255+255 -> 510; 0x0F+0x01 -> 0x10 (carry crosses the group boundary).
- WIDTH=16, GROUP=4: 0x7FFF+0x0001 -> 0x08000; 0xFFFF+0xFFFF -> 0x1FFFE. Plus 1000 random pairs checked against a behavioural + reference model.
- WIDTH=1: all 4 pairs -> results 0, 1, 1, 2.
